issue_scheduler: RTL

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/issue_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: pairs fetched slots A/B onto two issue ports, splitting
// dependent or control/illegal pairs so slot B issues alone one cycle later.
//
// state | meaning
// PAIR  | accepting fetch packets, issuing one or two instructions per cycle
// SPLIT | slot B of the last packet is buffered and issues next on port 0
module issue_scheduler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic        a_valid_i,
    input  logic        b_valid_i,
    input  logic [31:0] a_inst_i,
    input  logic [31:0] b_inst_i,
    input  logic [4:0]  a_info_i,
    input  logic [4:0]  b_info_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        p0_valid_o,
    output logic [31:0] p0_inst_o,
    output logic [4:0]  p0_info_o,
    output logic        p1_valid_o,
    output logic [31:0] p1_inst_o,
    output logic [4:0]  p1_info_o,
    output logic [15:0] dual_cnt_o
);

    typedef enum logic {
        PAIR  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    localparam int ILLEGAL  = 4;
    localparam int IS_CTRL  = 3;
    localparam int USES_RS1 = 2;
    localparam int USES_RS2 = 1;
    localparam int REGWRITE = 0;

    state_t      state, state_nxt;
    logic [31:0] buf_inst, buf_inst_nxt;
    logic [4:0]  buf_info, buf_info_nxt;

    logic        p0_valid_nxt, p1_valid_nxt;
    logic [31:0] p0_inst_nxt, p1_inst_nxt;
    logic [4:0]  p0_info_nxt, p1_info_nxt;
    logic        dual_load;
    logic        accept;

    logic [4:0]  a_rd, b_rd, b_rs1, b_rs2;
    logic        raw_hit, waw_hit, split;

    assign fetch_ready_o = (state == PAIR) && !stall_i && !flush_i;
    assign accept        = fetch_valid_i && fetch_ready_o;

    assign a_rd  = a_inst_i[11:7];
    assign b_rd  = b_inst_i[11:7];
    assign b_rs1 = b_inst_i[19:15];
    assign b_rs2 = b_inst_i[24:20];

    // x0 is hardwired zero, so it never carries a dependency
    assign raw_hit = a_info_i[REGWRITE] && (a_rd != 5'd0) &&
                     ((b_info_i[USES_RS1] && (b_rs1 == a_rd)) ||
                      (b_info_i[USES_RS2] && (b_rs2 == a_rd)));
    assign waw_hit = a_info_i[REGWRITE] && b_info_i[REGWRITE] &&
                     (a_rd != 5'd0) && (a_rd == b_rd);
    assign split   = raw_hit || waw_hit ||
                     a_info_i[IS_CTRL] || b_info_i[IS_CTRL] ||
                     a_info_i[ILLEGAL] || b_info_i[ILLEGAL];

    always_comb begin
        state_nxt    = state;
        buf_inst_nxt = buf_inst;
        buf_info_nxt = buf_info;
        p0_valid_nxt = p0_valid_o;
        p0_inst_nxt  = p0_inst_o;
        p0_info_nxt  = p0_info_o;
        p1_valid_nxt = p1_valid_o;
        p1_inst_nxt  = p1_inst_o;
        p1_info_nxt  = p1_info_o;
        dual_load    = 1'b0;

        if (flush_i) begin
            state_nxt    = PAIR;
            buf_inst_nxt = '0;
            buf_info_nxt = '0;
            p0_valid_nxt = 1'b0;
            p1_valid_nxt = 1'b0;
        end else if (!stall_i) begin
            p0_valid_nxt = 1'b0;
            p1_valid_nxt = 1'b0;
            case (state)
                SPLIT: begin
                    p0_valid_nxt = 1'b1;
                    p0_inst_nxt  = buf_inst;
                    p0_info_nxt  = buf_info;
                    state_nxt    = PAIR;
                end
                default: begin
                    if (accept) begin
                        if (a_valid_i) begin
                            p0_valid_nxt = 1'b1;
                            p0_inst_nxt  = a_inst_i;
                            p0_info_nxt  = a_info_i;
                            if (b_valid_i) begin
                                if (split) begin
                                    buf_inst_nxt = b_inst_i;
                                    buf_info_nxt = b_info_i;
                                    state_nxt    = SPLIT;
                                end else begin
                                    p1_valid_nxt = 1'b1;
                                    p1_inst_nxt  = b_inst_i;
                                    p1_info_nxt  = b_info_i;
                                    dual_load    = 1'b1;
                                end
                            end
                        end else if (b_valid_i) begin
                            p0_valid_nxt = 1'b1;
                            p0_inst_nxt  = b_inst_i;
                            p0_info_nxt  = b_info_i;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= PAIR;
            buf_inst   <= '0;
            buf_info   <= '0;
            p0_valid_o <= 1'b0;
            p0_inst_o  <= '0;
            p0_info_o  <= '0;
            p1_valid_o <= 1'b0;
            p1_inst_o  <= '0;
            p1_info_o  <= '0;
            dual_cnt_o <= '0;
        end else begin
            state      <= state_nxt;
            buf_inst   <= buf_inst_nxt;
            buf_info   <= buf_info_nxt;
            p0_valid_o <= p0_valid_nxt;
            p0_inst_o  <= p0_inst_nxt;
            p0_info_o  <= p0_info_nxt;
            p1_valid_o <= p1_valid_nxt;
            p1_inst_o  <= p1_inst_nxt;
            p1_info_o  <= p1_info_nxt;
            if (dual_load && (dual_cnt_o != 16'hFFFF))
                dual_cnt_o <= dual_cnt_o + 16'd1;
        end
    end

endmodule
